ball_controller: RTL and testbench
==================================

# ball_controller

Sequences ball motion for one paddle/floor playfield and keeps the game score. Once per `frameTick` it advances the ball position and bounces it off walls and the ceiling. It consumes the `ballTouchingPaddle`/`ballTouchingFloor` flags from the collision detector and runs the serve / play / miss / game-over flow. It sits between the VGA frame timing and the collision detector, and its `ballX`/`ballY` feed both the collision detector and the renderer.

## Interface
- `BIT_WIDTH`, 10: coordinate width.
- `SCREEN_W`, 640: playfield width in pixels.
- `SCREEN_H`, 480: playfield height in pixels. y increases upward.
- `BALL_RADIUS`, 4: ball radius in pixels.
- `FLOOR_Y`, 0: floor y-coordinate. Must match the collision detector.
- `SPEED`, 1: pixels moved per axis per frame. Must be 1 for exact-match paddle detection.
- `SERVE_X`, 320; `SERVE_Y`, 240: serve position.
- `SERVE_FRAMES`, 60: frames held at the serve position before motion starts.
- `MISS_FRAMES`, 30: frames paused after a miss.
- `LIVES`, 3: lives per game (1..7).
- `SCORE_WIDTH`, 8: score counter width.

Ports:
- `clk` in 1: single clock.
- `resetN` in 1: asynchronous, active-low reset.
- `frameTick` in 1: one-cycle pulse per video frame.
- `start` in 1: start-game request, level or pulse.
- `ballTouchingPaddle` in 1: collision flag, combinational from the current `ballX`/`ballY`.
- `ballTouchingFloor` in 1: collision flag.
- `ballX`, `ballY` out BIT_WIDTH: ball centre, registered.
- `score` out SCORE_WIDTH: paddle hits this game, saturating.
- `livesLeft` out 3: remaining lives.
- `playing` out 1: high in PLAY only.
- `gameOver` out 1: high in GAME_OVER only.

## Operation
- States: IDLE, SERVE, PLAY, MISS, GAME_OVER. Direction bits `dxNeg`, `dyNeg`.
- IDLE:
  - Ball held at (SERVE_X, SERVE_Y).
  - `start`=1 → SERVE; score←0, livesLeft←LIVES, frame counter←0.
- SERVE:
  - Ball at the serve position, dxNeg=1, dyNeg=0.
  - Counts frameTicks. On the SERVE_FRAMES-th tick → PLAY. No motion on that tick.
- PLAY, on each frameTick, priority order:
  1. `ballTouchingFloor`: livesLeft−1, ball position frozen. If livesLeft was 1 → GAME_OVER, otherwise → MISS with counter←0.
  2. `ballTouchingPaddle`: dxNeg toggled, score+1 (saturates at all-ones). The position then steps with the new direction on the same tick.
  3. Otherwise: step x by ±SPEED and y by ±SPEED.
- Wall/ceiling clamps, applied to the step:
  - Moving left with ballX ≤ BALL_RADIUS+SPEED: x←BALL_RADIUS, dxNeg←0.
  - Moving right with ballX+SPEED ≥ SCREEN_W−1−BALL_RADIUS: x←SCREEN_W−1−BALL_RADIUS, dxNeg←1.
  - Moving up with ballY+SPEED ≥ SCREEN_H−1−BALL_RADIUS: y←SCREEN_H−1−BALL_RADIUS, dyNeg←1.
  - Moving down: y never below FLOOR_Y+BALL_RADIUS. Reaching it raises the floor flag for the next tick.
  - A paddle toggle and a wall clamp on the same tick: the clamp wins for the direction bit.
- MISS: ball held. After MISS_FRAMES ticks → SERVE, counter←0; score and lives retained.
- GAME_OVER: ball held where it stopped. `start`=1 → SERVE with a new game (as from IDLE).
- `start` is ignored in SERVE, PLAY and MISS.
- Arithmetic:
  - Compare in BIT_WIDTH+1 bits so no sum wraps.
  - Frame counter width is ceil(log2(max(SERVE_FRAMES, MISS_FRAMES)+1)).

## Timing
- Reset (asynchronous, resetN=0):
  - State IDLE.
  - ballX=SERVE_X, ballY=SERVE_Y.
  - score=0, livesLeft=LIVES.
  - playing=0, gameOver=0.
  - dxNeg=1, dyNeg=0, counter=0.
- Reset mid-game aborts immediately to these values.
- All state and outputs change only on a clk edge where frameTick=1, except `start` transitions, which act on any edge.
- Position latency: one cycle after the frameTick edge.
- Collision flags are sampled only on frameTick cycles. Flags at other cycles are ignored.
- `start` and frameTick on the same edge in IDLE: enter SERVE with the counter still 0. That tick does not count.

## Test plan
1. Reset, then idle for 100 cycles → ball (320,240), score 0, livesLeft 3, playing 0, gameOver 0.
2. `start` pulse, then 60 frameTicks → playing rises after tick 60. Tick 61 → ball (319,241).
3. Serve with the paddle flag forced high on the first PLAY tick → score 1, dxNeg 0, ball (321,241). Hold the flag at score 255 → score stays 255.
4. Set SERVE_Y=470 (H=480, R=4) → after 5 PLAY ticks y=475 and dyNeg=1. Next tick y=474.
5. Floor flag on a PLAY tick → livesLeft 2, MISS for 30 ticks, then SERVE. Third floor hit → gameOver 1, livesLeft 0. `start` → score 0, livesLeft 3, SERVE.
6. Assert resetN low mid-PLAY, between clock edges → outputs return to reset values without a clock edge.

Source files
------------

// File: rtl/ball_controller.sv
// ---------------------------------------------------------------------------
// ball_controller
//   Sequences ball motion for a single paddle/floor playfield and keeps the
//   score. The ball advances once per frameTick and bounces off the side
//   walls and the ceiling. The serve / play / miss / game-over flow is driven
//   by the paddle and floor collision flags.
//
// Ports
//   clk                 single clock
//   resetN              asynchronous active-low reset
//   frameTick           one-cycle pulse per video frame
//   start               start-game request (level or pulse)
//   ballTouchingPaddle  collision flag from the current ballX/ballY
//   ballTouchingFloor   collision flag from the current ballX/ballY
//   ballX, ballY        registered ball centre (y increases upward)
//   score               paddle hits this game, saturating
//   livesLeft           remaining lives
//   playing             high in PLAY only
//   gameOver            high in GAME_OVER only
// ---------------------------------------------------------------------------
module ball_controller #(
    parameter int BIT_WIDTH    = 10,
    parameter int SCREEN_W     = 640,
    parameter int SCREEN_H     = 480,
    parameter int BALL_RADIUS  = 4,
    parameter int FLOOR_Y      = 0,
    parameter int SPEED        = 1,
    parameter int SERVE_X      = 320,
    parameter int SERVE_Y      = 240,
    parameter int SERVE_FRAMES = 60,
    parameter int MISS_FRAMES  = 30,
    parameter int LIVES        = 3,
    parameter int SCORE_WIDTH  = 8
) (
    input  logic                   clk,
    input  logic                   resetN,
    input  logic                   frameTick,
    input  logic                   start,
    input  logic                   ballTouchingPaddle,
    input  logic                   ballTouchingFloor,
    output logic [BIT_WIDTH-1:0]   ballX,
    output logic [BIT_WIDTH-1:0]   ballY,
    output logic [SCORE_WIDTH-1:0] score,
    output logic [2:0]             livesLeft,
    output logic                   playing,
    output logic                   gameOver
);

    typedef enum logic [2:0] {IDLE, SERVE, PLAY, MISS, GAME_OVER} state_t;

    localparam int CNT_MAX = (SERVE_FRAMES > MISS_FRAMES) ? SERVE_FRAMES : MISS_FRAMES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    // Limits are held one bit wider than the coordinates so no sum wraps.
    localparam logic [BIT_WIDTH:0] SPEED_W = (BIT_WIDTH+1)'(SPEED);
    localparam logic [BIT_WIDTH:0] X_LO    = (BIT_WIDTH+1)'(BALL_RADIUS);
    localparam logic [BIT_WIDTH:0] X_HI    = (BIT_WIDTH+1)'(SCREEN_W - 1 - BALL_RADIUS);
    localparam logic [BIT_WIDTH:0] Y_LO    = (BIT_WIDTH+1)'(FLOOR_Y + BALL_RADIUS);
    localparam logic [BIT_WIDTH:0] Y_HI    = (BIT_WIDTH+1)'(SCREEN_H - 1 - BALL_RADIUS);

    localparam logic [BIT_WIDTH-1:0] SX        = BIT_WIDTH'(SERVE_X);
    localparam logic [BIT_WIDTH-1:0] SY        = BIT_WIDTH'(SERVE_Y);
    localparam logic [CNT_W-1:0]     SERVE_END = CNT_W'(SERVE_FRAMES - 1);
    localparam logic [CNT_W-1:0]     MISS_END  = CNT_W'(MISS_FRAMES - 1);
    localparam logic [2:0]           LIVES_INIT = 3'(LIVES);

    state_t                 state, state_nxt;
    logic [BIT_WIDTH-1:0]   x_nxt, y_nxt;
    logic [SCORE_WIDTH-1:0] score_nxt;
    logic [2:0]             lives_nxt;
    logic [CNT_W-1:0]       cnt, cnt_nxt;
    logic                   dx_neg, dx_nxt;
    logic                   dy_neg, dy_nxt;
    logic                   dx_step;
    logic [BIT_WIDTH:0]     x_w, y_w;

    assign x_w = {1'b0, ballX};
    assign y_w = {1'b0, ballY};

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state     <= IDLE;
            ballX     <= SX;
            ballY     <= SY;
            score     <= '0;
            livesLeft <= LIVES_INIT;
            cnt       <= '0;
            dx_neg    <= 1'b1;
            dy_neg    <= 1'b0;
        end else begin
            state     <= state_nxt;
            ballX     <= x_nxt;
            ballY     <= y_nxt;
            score     <= score_nxt;
            livesLeft <= lives_nxt;
            cnt       <= cnt_nxt;
            dx_neg    <= dx_nxt;
            dy_neg    <= dy_nxt;
        end
    end

    always_comb begin
        // NOTE: every variable gets a hold value first so no path through
        // the case statement can infer a latch.
        state_nxt = state;
        x_nxt     = ballX;
        y_nxt     = ballY;
        score_nxt = score;
        lives_nxt = livesLeft;
        cnt_nxt   = cnt;
        dx_nxt    = dx_neg;
        dy_nxt    = dy_neg;
        dx_step   = dx_neg;

        case (state)
            IDLE, GAME_OVER: begin
                // start acts on any edge, independent of frameTick.
                if (start) begin
                    state_nxt = SERVE;
                    score_nxt = '0;
                    lives_nxt = LIVES_INIT;
                    cnt_nxt   = '0;
                    x_nxt     = SX;
                    y_nxt     = SY;
                    dx_nxt    = 1'b1;
                    dy_nxt    = 1'b0;
                end
            end

            SERVE: begin
                if (frameTick) begin
                    if (cnt == SERVE_END) begin
                        state_nxt = PLAY;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
            end

            PLAY: begin
                if (frameTick) begin
                    if (ballTouchingFloor) begin
                        lives_nxt = livesLeft - 1'b1;
                        if (livesLeft == 3'd1) begin
                            state_nxt = GAME_OVER;
                        end else begin
                            state_nxt = MISS;
                            cnt_nxt   = '0;
                        end
                    end else begin
                        // A paddle hit reverses x first; the step below
                        // then uses the new direction, and a wall clamp
                        // overrides the toggled bit.
                        if (ballTouchingPaddle) begin
                            dx_step = ~dx_neg;
                            if (score != {SCORE_WIDTH{1'b1}}) begin
                                score_nxt = score + 1'b1;
                            end
                        end
                        dx_nxt = dx_step;

                        if (dx_step) begin
                            if (x_w <= X_LO + SPEED_W) begin
                                x_nxt  = X_LO[BIT_WIDTH-1:0];
                                dx_nxt = 1'b0;
                            end else begin
                                x_nxt = ballX - SPEED_W[BIT_WIDTH-1:0];
                            end
                        end else begin
                            if (x_w + SPEED_W >= X_HI) begin
                                x_nxt  = X_HI[BIT_WIDTH-1:0];
                                dx_nxt = 1'b1;
                            end else begin
                                x_nxt = ballX + SPEED_W[BIT_WIDTH-1:0];
                            end
                        end

                        if (dy_neg) begin
                            // Floor contact is reported by the collision
                            // detector on the next tick; here we only stop
                            // the ball from sinking below it.
                            if (y_w < Y_LO + SPEED_W) begin
                                y_nxt = Y_LO[BIT_WIDTH-1:0];
                            end else begin
                                y_nxt = ballY - SPEED_W[BIT_WIDTH-1:0];
                            end
                        end else begin
                            if (y_w + SPEED_W >= Y_HI) begin
                                y_nxt  = Y_HI[BIT_WIDTH-1:0];
                                dy_nxt = 1'b1;
                            end else begin
                                y_nxt = ballY + SPEED_W[BIT_WIDTH-1:0];
                            end
                        end
                    end
                end
            end

            MISS: begin
                if (frameTick) begin
                    if (cnt == MISS_END) begin
                        state_nxt = SERVE;
                        cnt_nxt   = '0;
                        x_nxt     = SX;
                        y_nxt     = SY;
                        dx_nxt    = 1'b1;
                        dy_nxt    = 1'b0;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
            end

            default: state_nxt = IDLE;
        endcase
    end

    assign playing  = (state == PLAY);
    assign gameOver = (state == GAME_OVER);

endmodule

// File: tb/tb_ball_controller.sv
// ---------------------------------------------------------------------------
// tb_ball_controller
//   Directed bench for ball_controller. Two instances share all inputs: the
//   default one and one serving at y=470 to exercise the ceiling clamp.
// ---------------------------------------------------------------------------
module tb_ball_controller;

    logic       clk = 1'b0;
    logic       resetN = 1'b0;
    logic       frameTick = 1'b0;
    logic       start = 1'b0;
    logic       paddle = 1'b0;
    logic       floor_hit = 1'b0;

    logic [9:0] ball_x, ball_y, ball_x2, ball_y2;
    logic [7:0] score, score2;
    logic [2:0] lives, lives2;
    logic       playing, playing2, game_over, game_over2;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ball_controller dut (
        .clk(clk), .resetN(resetN), .frameTick(frameTick), .start(start),
        .ballTouchingPaddle(paddle), .ballTouchingFloor(floor_hit),
        .ballX(ball_x), .ballY(ball_y), .score(score), .livesLeft(lives),
        .playing(playing), .gameOver(game_over)
    );

    ball_controller #(.SERVE_Y(470)) dut_high (
        .clk(clk), .resetN(resetN), .frameTick(frameTick), .start(start),
        .ballTouchingPaddle(paddle), .ballTouchingFloor(floor_hit),
        .ballX(ball_x2), .ballY(ball_y2), .score(score2), .livesLeft(lives2),
        .playing(playing2), .gameOver(game_over2)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One frame tick with the given collision flags; returns at a negedge.
    task automatic tick(input logic p, input logic f);
        @(negedge clk);
        frameTick = 1'b1;
        paddle    = p;
        floor_hit = f;
        @(negedge clk);
        frameTick = 1'b0;
        paddle    = 1'b0;
        floor_hit = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        resetN = 1'b1;

        // Reset / idle
        repeat (100) @(negedge clk);
        check("idle_x", ball_x, 320);
        check("idle_y", ball_y, 240);
        check("idle_score", score, 0);
        check("idle_lives", lives, 3);
        check("idle_playing", playing, 0);
        check("idle_gameover", game_over, 0);

        // Serve: 60 ticks, motion starts on tick 61
        pulse_start();
        ticks(59);
        check("serve59_playing", playing, 0);
        tick(1'b0, 1'b0);
        check("serve60_playing", playing, 1);
        check("serve60_x", ball_x, 320);
        check("serve60_y", ball_y, 240);
        tick(1'b0, 1'b0);
        check("play1_x", ball_x, 319);
        check("play1_y", ball_y, 241);
        check("play1_y_high", ball_y2, 471);

        // Ceiling clamp on the high-serve instance
        ticks(4);
        check("ceil_y", ball_y2, 475);
        check("ceil_x_main", ball_x, 315);
        tick(1'b0, 1'b0);
        check("ceil_next_y", ball_y2, 474);
        check("play6_x", ball_x, 314);
        check("play6_y", ball_y, 246);

        // Flags outside frame ticks are ignored
        @(negedge clk);
        floor_hit = 1'b1;
        paddle    = 1'b1;
        repeat (3) @(negedge clk);
        floor_hit = 1'b0;
        paddle    = 1'b0;
        check("offtick_lives", lives, 3);
        check("offtick_score", score, 0);
        check("offtick_x", ball_x, 314);

        // First miss
        tick(1'b0, 1'b1);
        check("miss1_lives", lives, 2);
        check("miss1_playing", playing, 0);
        check("miss1_x", ball_x, 314);
        check("miss1_y", ball_y, 246);
        ticks(29);
        check("miss29_x", ball_x, 314);
        tick(1'b0, 1'b0);
        check("miss30_x", ball_x, 320);
        check("miss30_y", ball_y, 240);
        ticks(60);
        check("reserve_playing", playing, 1);

        // Paddle hit on first PLAY tick, then saturation
        tick(1'b1, 1'b0);
        check("paddle_score", score, 1);
        check("paddle_x", ball_x, 321);
        check("paddle_y", ball_y, 241);
        pulse_start();
        check("start_in_play", playing, 1);
        check("start_in_play_score", score, 1);
        for (int i = 0; i < 254; i++) tick(1'b1, 1'b0);
        check("score_255", score, 255);
        tick(1'b1, 1'b0);
        check("score_sat", score, 255);
        check("score_lives", lives, 2);

        // Second and third miss -> game over
        tick(1'b0, 1'b1);
        check("miss2_lives", lives, 1);
        ticks(90);
        check("serve3_playing", playing, 1);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b1);
        check("over_flag", game_over, 1);
        check("over_lives", lives, 0);
        check("over_playing", playing, 0);
        check("over_x", ball_x, 319);
        check("over_y", ball_y, 241);
        check("over_score", score, 255);

        // Restart from game over
        pulse_start();
        check("restart_over", game_over, 0);
        check("restart_score", score, 0);
        check("restart_lives", lives, 3);
        check("restart_x", ball_x, 320);
        check("restart_y", ball_y, 240);
        ticks(60);
        check("restart_playing", playing, 1);

        // Asynchronous reset mid-play, between edges
        tick(1'b1, 1'b0);
        check("pre_reset_score", score, 1);
        #2 resetN = 1'b0;
        #1;
        check("rst_x", ball_x, 320);
        check("rst_y", ball_y, 240);
        check("rst_score", score, 0);
        check("rst_lives", lives, 3);
        check("rst_playing", playing, 0);
        check("rst_gameover", game_over, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Watchdog: guarantees termination even if the sequence stalls.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
